// File: rtl/osnt_bram_pkg.sv
// osnt_bram_pkg: shared widths, address shift and FSM encoding for the BRAM replay reader
package osnt_bram_pkg;
  localparam int WORD_ADDR_SHIFT = 6;
  localparam int DEF_ADDR_WIDTH = 20;
  localparam int DEF_DATA_WIDTH = 1282;
  localparam int DEF_TDATA_WIDTH = 1024;
  localparam int DEF_TUSER_WIDTH = 128;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING, S_FLUSH} state_t;
endpackage

// File: rtl/osnt_bram_rd_fifo.sv
// osnt_bram_rd_fifo: small synchronous prefetch FIFO; the caller's credit check prevents overflow
module osnt_bram_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 1281
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign head = mem[rd_ptr];
  // storage is not reset; only pointers and count define occupancy
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/osnt_bram_replay_reader.sv
// osnt_bram_replay_reader: replays stored AXI-Stream beats from a BRAM word region with looping and graceful stop
module osnt_bram_replay_reader
  import osnt_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  bram_clk,
  input  logic                                  bram_rst,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic [ADDR_WIDTH-WORD_ADDR_SHIFT-1:0] cfg_base_word,
  input  logic [ADDR_WIDTH-WORD_ADDR_SHIFT-1:0] cfg_num_words,
  input  logic [15:0]                           cfg_loops,
  output logic                                  busy,
  output logic                                  done,
  output logic [31:0]                           pkt_count,
  output logic [15:0]                           loop_count,
  output logic [ADDR_WIDTH-1:0]                 bram_addr,
  output logic                                  bram_en,
  output logic [DATA_WIDTH/8-1:0]               bram_we,
  output logic [DATA_WIDTH-1:0]                 bram_wrdata,
  input  logic [DATA_WIDTH-1:0]                 bram_rddata,
  output logic [TDATA_WIDTH-1:0]                m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]              m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]                m_axis_tuser,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready
);
  localparam int IW = ADDR_WIDTH - WORD_ADDR_SHIFT;
  localparam int KW = TDATA_WIDTH / 8;
  localparam int USER_LSB = TDATA_WIDTH;
  localparam int KEEP_LSB = USER_LSB + TUSER_WIDTH;
  localparam int LAST_BIT = KEEP_LSB + KW;
  localparam int VALID_BIT = LAST_BIT + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t state;
  logic [IW-1:0] base_r, num_r, idx, pos;
  logic [15:0] loops_r;
  logic inflight, push, pop, wrap, limit, stop_done, issue;
  logic [CW-1:0] fifo_count;
  logic [LAST_BIT:0] head;
  // a returned word is kept only when its stored tvalid flag is set
  assign push = inflight && bram_rddata[VALID_BIT];
  // in STOPPING, the first kept tlast word ends the replay, so nothing is issued alongside it
  assign stop_done = state == S_STOPPING && push && bram_rddata[LAST_BIT];
  assign wrap = pos == num_r - IW'(1);
  assign limit = loops_r != 16'd0 && loop_count + 16'd1 == loops_r;
  // credit rule: FIFO entries plus the outstanding read never exceed the FIFO depth
  assign issue = (state == S_RUN || state == S_STOPPING) && !stop_done &&
                 (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign busy = state != S_IDLE;
  assign bram_en = issue;
  assign bram_addr = {idx, {WORD_ADDR_SHIFT{1'b0}}};
  assign bram_we = '0;
  assign bram_wrdata = '0;
  assign m_axis_tvalid = fifo_count != '0;
  assign m_axis_tdata = m_axis_tvalid ? head[TDATA_WIDTH-1:0] : '0;
  assign m_axis_tuser = m_axis_tvalid ? head[KEEP_LSB-1:USER_LSB] : '0;
  assign m_axis_tkeep = m_axis_tvalid ? head[LAST_BIT-1:KEEP_LSB] : '0;
  assign m_axis_tlast = m_axis_tvalid && head[LAST_BIT];

  osnt_bram_rd_fifo #(.DEPTH(FIFO_DEPTH), .W(LAST_BIT + 1)) u_fifo (
    .clk(bram_clk),
    .rst(bram_rst),
    .push(push),
    .pop(pop),
    .din(bram_rddata[LAST_BIT:0]),
    .head(head),
    .count(fifo_count)
  );

  // control FSM: region walk, loop accounting, stop handling and drain
  always_ff @(posedge bram_clk) begin
    if (bram_rst) begin
      state <= S_IDLE;
      base_r <= '0;
      num_r <= '0;
      loops_r <= '0;
      idx <= '0;
      pos <= '0;
      inflight <= 1'b0;
      done <= 1'b0;
      pkt_count <= '0;
      loop_count <= '0;
    end else begin
      inflight <= issue;
      done <= 1'b0;
      if (pop && m_axis_tlast) pkt_count <= pkt_count + 32'd1;
      if (issue) begin
        idx <= wrap ? base_r : idx + IW'(1);
        pos <= wrap ? '0 : pos + IW'(1);
        if (wrap) loop_count <= loop_count + 16'd1;
      end
      case (state)
        S_IDLE: if (start) begin
          base_r <= cfg_base_word;
          num_r <= cfg_num_words;
          loops_r <= cfg_loops;
          idx <= cfg_base_word;
          pos <= '0;
          pkt_count <= '0;
          loop_count <= '0;
          state <= cfg_num_words == '0 ? S_FLUSH : S_RUN;
        end
        S_RUN: begin
          if (issue && wrap && limit) state <= S_FLUSH;
          else if (stop) state <= S_STOPPING;
        end
        S_STOPPING: if (stop_done || (issue && wrap && limit)) state <= S_FLUSH;
        S_FLUSH: if (fifo_count == '0 && !inflight) begin
          state <= S_IDLE;
          done <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_osnt_bram_replay_reader.sv
// tb_osnt_bram_replay_reader: directed scenarios with random payloads against a region-walk reference model
module tb_osnt_bram_replay_reader;
  localparam int AW = 20, DW = 1282, TW = 1024, UW = 128, IW = 14, PW = 1281;
  logic clk = 0, rst = 1, start = 0, stop = 0, tready = 1;
  logic [IW-1:0] cfg_base = '0, cfg_num = '0;
  logic [15:0] cfg_loops = '0;
  logic busy, done, bram_en, tvalid, tlast;
  logic [31:0] pkt_count;
  logic [15:0] loop_count;
  logic [AW-1:0] bram_addr;
  logic [DW/8-1:0] bram_we;
  logic [DW-1:0] bram_wrdata, bram_rddata = '0;
  logic [TW-1:0] tdata;
  logic [TW/8-1:0] tkeep;
  logic [UW-1:0] tuser;
  logic [PW-1:0] beat;
  logic [DW-1:0] mem [int];
  logic [PW-1:0] got_q[$], exp_q[$];
  logic [AW-1:0] addr_q[$];
  int cyc_q[$];
  int cyc = 0, done_cnt = 0, passed = 0, total = 0, fails = 0;

  always #5 clk = ~clk;
  assign beat = {tlast, tkeep, tuser, tdata};

  osnt_bram_replay_reader dut (
    .bram_clk(clk), .bram_rst(rst), .start(start), .stop(stop),
    .cfg_base_word(cfg_base), .cfg_num_words(cfg_num), .cfg_loops(cfg_loops),
    .busy(busy), .done(done), .pkt_count(pkt_count), .loop_count(loop_count),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we), .bram_wrdata(bram_wrdata),
    .bram_rddata(bram_rddata), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tuser(tuser),
    .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tready(tready)
  );

  function automatic logic [DW-1:0] rd(input int i);
    return mem.exists(i) ? mem[i] : '0;
  endfunction

  // BRAM port: registered read, data one cycle after enable
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bram_en) bram_rddata <= rd(int'(bram_addr[AW-1:6]));
  end

  // observe handshakes, issued reads and done pulses
  always @(negedge clk) begin
    if (tvalid && tready) begin
      got_q.push_back(beat);
      cyc_q.push_back(cyc);
    end
    if (bram_en) addr_q.push_back(bram_addr);
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got_low=%0h exp_low=%0h", tag, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [DW-1:0] mkword(input bit v, input bit l);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < 40; i++) w[i*32 +: 32] = $urandom;
    w[DW-1] = v;
    w[DW-2] = l;
    return w;
  endfunction

  // reference: every pass walks base..base+num-1 modulo memory size; only tvalid words appear
  function automatic void build(input int base, input int num, input int loops);
    logic [DW-1:0] w;
    exp_q.delete();
    for (int p = 0; p < loops; p++)
      for (int k = 0; k < num; k++) begin
        w = rd((base + k) % (1 << IW));
        if (w[DW-1]) exp_q.push_back(w[PW-1:0]);
      end
  endfunction

  task automatic clear_obs();
    got_q.delete();
    cyc_q.delete();
    addr_q.delete();
  endtask

  task automatic do_start(input int base, input int num, input int loops);
    cfg_base = IW'(base);
    cfg_num = IW'(num);
    cfg_loops = 16'(loops);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic cmp_stream(input string tag, input int n);
    chk({tag, "_len"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++)
      chkw($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  // mode 0: ready high, 1: ready toggles, 2: random ready; also checks hold while stalled
  task automatic run_until_done(input int mode, input int bound, input string tag);
    int n, d0;
    logic pv, pr;
    logic [PW-1:0] pb;
    n = 0;
    d0 = done_cnt;
    pv = 0;
    pr = 1;
    pb = '0;
    while (done_cnt == d0 && n < bound) begin
      if (pv && !pr) begin
        chk({tag, "_hold_valid"}, 64'(tvalid), 64'd1);
        chkw({tag, "_hold_payload"}, beat, pb);
      end
      pv = tvalid;
      pb = beat;
      tready = mode == 0 ? 1'b1 : mode == 1 ? ~tready : 1'($urandom_range(0, 1));
      pr = tready;
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    tready = 1;
  endtask

  initial begin
    int d0, n, sz;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_pkt", 64'(pkt_count), 0);
    chk("rst_loop", 64'(loop_count), 0);
    chk("rst_en", 64'(bram_en), 0);
    chk("rst_addr", 64'(bram_addr), 0);
    chk("rst_tvalid", 64'(tvalid), 0);
    chk("rst_tlast", 64'(tlast), 0);
    chk("rst_payload_zero", 64'(tdata === '0 && tkeep === '0 && tuser === '0), 1);
    chk("we_wrdata_zero", 64'(bram_we === '0 && bram_wrdata === '0), 1);
    rst = 0;
    tick();

    // single pass, one 4-word packet at word 0x10
    for (int i = 0; i < 4; i++) mem[16 + i] = mkword(1, i == 3);
    clear_obs();
    d0 = done_cnt;
    do_start(16, 4, 1);
    chk("t1_busy", 64'(busy), 1);
    chk("t1_tvalid_c0", 64'(tvalid), 0);
    tick();
    chk("t1_tvalid_c1", 64'(tvalid), 0);
    tick();
    chk("t1_tvalid_c2", 64'(tvalid), 1);
    run_until_done(0, 100, "t1");
    repeat (3) tick();
    build(16, 4, 1);
    cmp_stream("t1", 4);
    chk("t1_b2b", cyc_q.size() == 4 ? 64'(cyc_q[3] - cyc_q[0]) : 64'hFFFF, 3);
    chk("t1_naddr", 64'(addr_q.size()), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      chk($sformatf("t1_addr%0d", i), 64'(addr_q[i]), 64'('h400 + 'h40 * i));
    chk("t1_pkt", 64'(pkt_count), 1);
    chk("t1_loop", 64'(loop_count), 1);
    chk("t1_done_once", 64'(done_cnt - d0), 1);
    chk("t1_idle", 64'(busy), 0);

    // three passes with toggling ready
    clear_obs();
    do_start(16, 4, 3);
    run_until_done(1, 400, "t2");
    repeat (3) tick();
    build(16, 4, 3);
    cmp_stream("t2", 12);
    chk("t2_pkt", 64'(pkt_count), 3);
    chk("t2_loop", 64'(loop_count), 3);

    // padding words dropped; region wraps over the top of memory
    for (int p = 0; p < 6; p++) mem[(16382 + p) % (1 << IW)] = mkword(p != 2 && p != 4, p == 5);
    clear_obs();
    do_start(16382, 6, 1);
    run_until_done(2, 400, "t3");
    repeat (3) tick();
    build(16382, 6, 1);
    cmp_stream("t3", 4);
    chk("t3_addr_top", addr_q.size() > 1 ? 64'(addr_q[1]) : 64'hFFFF, 64'hFFFC0);
    chk("t3_addr_wrap", addr_q.size() > 2 ? 64'(addr_q[2]) : 64'hFFFF, 0);
    chk("t3_pkt", 64'(pkt_count), 1);

    // infinite loop, stop while the second packet is being read
    for (int p = 0; p < 6; p++) mem[256 + p] = mkword(1, p == 2 || p == 5);
    clear_obs();
    d0 = done_cnt;
    do_start(256, 6, 0);
    n = 0;
    while (addr_q.size() < 5 && n < 200) begin
      tick();
      n++;
    end
    chk("t4_reached_pkt2", 64'(addr_q.size() >= 5), 1);
    stop = 1;
    tick();
    stop = 0;
    run_until_done(0, 200, "t4");
    repeat (5) tick();
    build(256, 6, 2);
    cmp_stream("t4", 6);
    sz = got_q.size();
    chk("t4_ends_tlast", sz > 0 ? 64'(got_q[sz-1][PW-1]) : 0, 1);
    chk("t4_pkt", 64'(pkt_count), 2);
    chk("t4_quiet", 64'(tvalid), 0);
    chk("t4_done_once", 64'(done_cnt - d0), 1);

    // empty region
    clear_obs();
    do_start(40, 0, 1);
    chk("t5_busy", 64'(busy), 1);
    chk("t5_done_c0", 64'(done), 0);
    tick();
    chk("t5_done_c1", 64'(done), 1);
    chk("t5_idle", 64'(busy), 0);
    tick();
    chk("t5_done_pulse", 64'(done), 0);
    chk("t5_no_reads", 64'(addr_q.size()), 0);
    chk("t5_pkt", 64'(pkt_count), 0);
    chk("t5_loop", 64'(loop_count), 0);

    // reset in the middle of a packet with a read outstanding, then replay
    clear_obs();
    do_start(16, 4, 0);
    n = 0;
    while (got_q.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    rst = 1;
    tick();
    chk("t6_tvalid", 64'(tvalid), 0);
    chk("t6_en", 64'(bram_en), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_pkt", 64'(pkt_count), 0);
    rst = 0;
    tick();
    tick();
    chk("t6_still_quiet", 64'(tvalid), 0);
    clear_obs();
    do_start(16, 4, 1);
    run_until_done(0, 100, "t6");
    repeat (3) tick();
    build(16, 4, 1);
    cmp_stream("t6", 4);
    chk("t6_addr0", addr_q.size() > 0 ? 64'(addr_q[0]) : 0, 64'h400);
    chk("t6_pkt_after", 64'(pkt_count), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/osnt_bram_replay_reader.md
Name: osnt_bram_replay_reader

Overview:
- Read-side master for the packet-store BRAM. Each 1282-bit word holds one AXI-Stream beat (TDATA/TUSER/TKEEP/TVALID/TLAST).
- On command, walks a word region, reads each word through a single BRAM port and re-emits the stored beats as a 1024-bit AXI-Stream master.
- Supports loop count, graceful stop and backpressure. Sits between the store and the generator TX path.

Parameters:
- ADDR_WIDTH, 20, BRAM byte address width; word index is addr[ADDR_WIDTH-1:6].
- DATA_WIDTH, 1282, BRAM word width.
- TDATA_WIDTH, 1024, stream data width.
- TUSER_WIDTH, 128, stream user width.
- FIFO_DEPTH, 4, prefetch FIFO entries; must be >=3 for one beat per cycle.

Ports:
- bram_clk  in  1  single clock for BRAM port and stream.
- bram_rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; accepted only in IDLE.
- stop  in  1  pulse; graceful stop request.
- cfg_base_word  in  ADDR_WIDTH-6  first word index.
- cfg_num_words  in  ADDR_WIDTH-6  words per pass; 0 means empty.
- cfg_loops  in  16  passes; 0 means infinite until stop.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- pkt_count  out  32  TLAST handshakes since start; wraps.
- loop_count  out  16  completed passes since start.
- bram_addr  out  ADDR_WIDTH  {word_idx, 6'b0}.
- bram_en  out  1  read enable.
- bram_we  out  DATA_WIDTH/8  tied to 0.
- bram_wrdata  out  DATA_WIDTH  tied to 0.
- bram_rddata  in  DATA_WIDTH  registered read data, valid 1 cycle after bram_en.
- m_axis_tdata  out  TDATA_WIDTH  stream data.
- m_axis_tkeep  out  TDATA_WIDTH/8  stream byte enables.
- m_axis_tuser  out  TUSER_WIDTH  stream user.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tlast  out  1  stream last.
- m_axis_tready  in  1  stream ready.

Behaviour:
- Word layout: [1023:0] tdata, [1151:1024] tuser, [1279:1152] tkeep, [1280] tlast, [1281] tvalid.
- Reset state: all outputs 0 (busy, done, counters, bram_en, m_axis_*). State=IDLE. FIFO emptied. In-flight read discarded.
- States: IDLE, RUN, STOPPING, FLUSH.
- IDLE -> RUN on start:
  - latch cfg_*, idx=cfg_base_word, clear pkt_count and loop_count.
  - If cfg_num_words==0: go straight to FLUSH; no reads issued.
- RUN, read issue: bram_en=1 when (fifo_count + inflight) < FIFO_DEPTH; addr={idx,6'b0}; inflight=1 for the next cycle only.
- Index advance:
  - idx increments per issued read.
  - After word base+num_words-1: idx=base and loop_count++.
  - If loop_count reaches cfg_loops (cfg_loops!=0): stop issuing, go to FLUSH.
  - Index arithmetic is modulo 2^(ADDR_WIDTH-6); a region crossing the top of memory wraps to word 0.
- Return data: one cycle after an issue, the word is pushed into the FIFO if its tvalid bit=1; words with tvalid=0 are padding and dropped.
- STOPPING (entered from RUN on stop):
  - keep issuing reads until a returned word with tvalid=1 and tlast=1 is pushed; then cease issuing;
  - any later in-flight return is discarded;
  - go to FLUSH. Stop therefore never truncates a packet.
  - If the loop limit is hit while in STOPPING, go to FLUSH.
- FLUSH -> IDLE when FIFO empty and inflight=0; done=1 for that cycle.
- Simultaneous events:
  - start while busy: ignored.
  - stop in IDLE or FLUSH: ignored.
  - stop in the same cycle as the loop-limit wrap: FLUSH wins.
- AXIS rules:
  - FIFO head drives m_axis_*.
  - tvalid must not drop and payload must not change until tready.
  - Pop on tvalid&tready.
  - pkt_count++ on a popped beat with tlast.
- Throughput: one beat/cycle with tready=1 and FIFO_DEPTH>=3.
- First tvalid appears 2 cycles after start is accepted.
- The region must end on a tlast word; the block does not fix malformed regions.

Decomposition:
- Package osnt_bram_pkg: word field offsets/widths, state enum, WORD_ADDR_SHIFT=6.
- Sub-module osnt_bram_rd_fifo: synchronous FIFO, DEPTH x 1281 bits, push/pop/count, no full-drop (the credit rule guarantees no overflow).

Test Plan:
- base=0x10, num=4 words (tlast on word 3), loops=1, tready=1 -> 4 beats on consecutive cycles, first tvalid 2 cycles after start; addrs 0x400,0x440,0x480,0x4C0; pkt_count=1, loop_count=1, done pulse.
- Same region, loops=3, tready toggling 1/0 each cycle -> 12 beats in stored order, payload stable while tready=0, pkt_count=3, no FIFO overflow.
- Region of 6 words where words 2 and 4 have tvalid=0 -> exactly 4 beats out, padding absent.
- loops=0, 2 packets of 3 words, stop asserted mid-second-packet -> that packet completes through its tlast; no further beats; done pulses.
- cfg_num_words=0 with start -> bram_en never asserted, done 1 cycle later, counters 0.
- bram_rst asserted mid-packet with a read in flight -> next cycle m_axis_tvalid=0, bram_en=0, busy=0; a fresh start replays from base correctly.
